// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its multdiv park queue.
package wb_pkg;

    localparam int RSTATUS_REG_DEF = 30;

    localparam logic [31:0] ST_ADD_OVF  = 32'd1;
    localparam logic [31:0] ST_ADDI_OVF = 32'd2;
    localparam logic [31:0] ST_SUB_OVF  = 32'd3;
    localparam logic [31:0] ST_MUL_OVF  = 32'd4;
    localparam logic [31:0] ST_DIV_ZERO = 32'd5;

    // valid drops when a younger ALU write to the same register squashes the entry
    typedef struct packed {
        logic        valid;
        logic [4:0]  wreg;
        logic [31:0] data;
    } wb_entry_t;

    // One-hot register mask; r0 is hardwired so it never appears as pending
    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        logic [31:0] m;
        if (r == 5'd0) begin
            m = 32'd0;
        end else begin
            m = 32'd1 << r;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_park_queue.sv
// Circular FIFO parking multdiv results that lost the regfile port; supports
// invalidating every entry aimed at a given register and reports a pending mask.
module wb_park_queue
    import wb_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        push_i,
    input  wb_entry_t   push_entry_i,
    input  logic        pop_i,
    input  logic        squash_i,
    input  logic [4:0]  squash_reg_i,
    output wb_entry_t   head_o,
    output logic        empty_o,
    output logic        full_o,
    output logic [31:0] mask_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    wb_entry_t         entries_q [QDEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push_s;
    logic              do_pop_s;
    logic [31:0]       mask_s;

    assign empty_o   = (count_q == CW'(0));
    assign full_o    = (count_q == CW'(QDEPTH));
    assign head_o    = entries_q[rd_ptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & ~full_o;
    assign mask_o    = mask_s;

    // Storage, pointers and occupancy; squash first so a same-cycle push is not affected
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (squash_i && (entries_q[i].wreg == squash_reg_i)) begin
                    entries_q[i].valid <= 1'b0;
                end
            end
            if (do_pop_s) begin
                entries_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push_s) begin
                entries_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Pending-register mask over live entries (popped/squashed entries have valid=0)
    always_comb begin
        mask_s = 32'd0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (entries_q[i].valid) begin
                mask_s = mask_s | reg_onehot(entries_q[i].wreg);
            end else begin
                mask_s = mask_s;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU > parked multdiv > direct multdiv onto the single regfile port.
// Optional macro WB_FORWARD_EN enables forwarding of the in-flight regfile write to decode.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int QDEPTH      = 2,
    parameter int RSTATUS_REG = RSTATUS_REG_DEF
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        alu_exc,
    input  logic [31:0] alu_exc_code,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_exc,
    input  logic [31:0] md_exc_code,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pending_mask,
    input  logic [4:0]  fwd_rd_a,
    input  logic [4:0]  fwd_rd_b,
    output logic        fwd_hit_a,
    output logic        fwd_hit_b,
    output logic [31:0] fwd_data_a,
    output logic [31:0] fwd_data_b
);

    localparam logic [4:0] RST_REG = 5'(RSTATUS_REG);

    logic [4:0]  alu_reg_s;
    logic [31:0] alu_val_s;
    logic [4:0]  md_reg_s;
    logic [31:0] md_val_s;
    logic        md_xfer_s;
    logic        q_push_s;
    logic        q_pop_s;
    logic        q_squash_s;
    logic        q_empty_s;
    logic        q_full_s;
    wb_entry_t   q_head_s;
    wb_entry_t   q_push_entry_s;
    logic        we_d, we_q;
    logic [4:0]  wreg_d, wreg_q;
    logic [31:0] wdata_d, wdata_q;

    assign alu_reg_s = alu_exc ? RST_REG : alu_rd;
    assign alu_val_s = alu_exc ? alu_exc_code : alu_data;
    assign md_reg_s  = md_exc ? RST_REG : md_rd;
    assign md_val_s  = md_exc ? md_exc_code : md_data;
    assign md_ready  = ~q_full_s;
    assign md_xfer_s = md_valid & ~q_full_s;
    assign q_push_entry_s = '{valid: 1'b1, wreg: md_reg_s, data: md_val_s};

    wb_park_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .push_i       (q_push_s),
        .push_entry_i (q_push_entry_s),
        .pop_i        (q_pop_s),
        .squash_i     (q_squash_s),
        .squash_reg_i (alu_reg_s),
        .head_o       (q_head_s),
        .empty_o      (q_empty_s),
        .full_o       (q_full_s),
        .mask_o       (pending_mask)
    );

    // Port owner select; an md result colliding with an ALU write to the same reg is dropped
    always_comb begin
        we_d       = 1'b0;
        wreg_d     = 5'd0;
        wdata_d    = 32'd0;
        q_push_s   = 1'b0;
        q_pop_s    = 1'b0;
        q_squash_s = 1'b0;
        if (alu_valid) begin
            if (alu_reg_s != 5'd0) begin
                we_d       = 1'b1;
                wreg_d     = alu_reg_s;
                wdata_d    = alu_val_s;
                q_squash_s = 1'b1;
            end else begin
                we_d = 1'b0;
            end
            q_push_s = md_xfer_s && (md_reg_s != 5'd0) && (md_reg_s != alu_reg_s);
        end else if (!q_empty_s) begin
            q_pop_s = 1'b1;
            if (q_head_s.valid && (q_head_s.wreg != 5'd0)) begin
                we_d    = 1'b1;
                wreg_d  = q_head_s.wreg;
                wdata_d = q_head_s.data;
            end else begin
                we_d = 1'b0;
            end
            q_push_s = md_xfer_s && (md_reg_s != 5'd0);
        end else if (md_xfer_s && (md_reg_s != 5'd0)) begin
            we_d    = 1'b1;
            wreg_d  = md_reg_s;
            wdata_d = md_val_s;
        end else begin
            we_d = 1'b0;
        end
    end

    // Registered regfile write port
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

`ifdef WB_FORWARD_EN
    // The regfile reads high-Z while writing the same reg, so decode takes the value from here
    assign fwd_hit_a  = we_q && (wreg_q == fwd_rd_a) && (fwd_rd_a != 5'd0);
    assign fwd_hit_b  = we_q && (wreg_q == fwd_rd_b) && (fwd_rd_b != 5'd0);
    assign fwd_data_a = wdata_q;
    assign fwd_data_b = wdata_q;
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{fwd_rd_a, fwd_rd_b};
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = 32'd0;
    assign fwd_data_b = 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter (QDEPTH=2) plus a hand-written reset sequence.
module tb_wb_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        alu_valid, alu_exc, md_valid, md_exc;
    logic [4:0]  alu_rd, md_rd, fwd_rd_a, fwd_rd_b;
    logic [31:0] alu_data, alu_exc_code, md_data, md_exc_code;
    logic        md_ready, ctrl_writeEnable, fwd_hit_a, fwd_hit_b;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg, pending_mask, fwd_data_a, fwd_data_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    wb_arbiter #(.QDEPTH(2), .RSTATUS_REG(30)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_exc(alu_exc), .alu_exc_code(alu_exc_code),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .md_exc(md_exc), .md_exc_code(md_exc_code),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .pending_mask(pending_mask),
        .fwd_rd_a(fwd_rd_a), .fwd_rd_b(fwd_rd_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        aexc;
        logic [31:0] acode;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        mexc;
        logic [31:0] mcode;
        logic        ewe;
        logic [4:0]  ereg;
        logic [31:0] edata;
        logic        erdy;
        logic [31:0] emask;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t v(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic aexc, input logic [31:0] acode,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                               input logic mexc, input logic [31:0] mcode,
                               input logic ewe, input logic [4:0] ereg, input logic [31:0] edata,
                               input logic erdy, input logic [31:0] emask);
        vec_t r;
        r.av = av; r.ard = ard; r.adata = adata; r.aexc = aexc; r.acode = acode;
        r.mv = mv; r.mrd = mrd; r.mdata = mdata; r.mexc = mexc; r.mcode = mcode;
        r.ewe = ewe; r.ereg = ereg; r.edata = edata; r.erdy = erdy; r.emask = emask;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic ewe, input logic [4:0] ereg,
                              input logic [31:0] edata, input logic erdy, input logic [31:0] emask);
        logic ehit_a, ehit_b;
        logic [31:0] efd;
`ifdef WB_FORWARD_EN
        ehit_a = ewe && (ereg == fwd_rd_a) && (fwd_rd_a != 5'd0);
        ehit_b = ewe && (ereg == fwd_rd_b) && (fwd_rd_b != 5'd0);
        efd    = edata;
`else
        ehit_a = 1'b0;
        ehit_b = 1'b0;
        efd    = 32'd0;
`endif
        check({tag, ".we"},    {31'd0, ctrl_writeEnable}, {31'd0, ewe});
        check({tag, ".reg"},   {27'd0, ctrl_writeReg},    {27'd0, ereg});
        check({tag, ".data"},  data_writeReg,             edata);
        check({tag, ".ready"}, {31'd0, md_ready},         {31'd0, erdy});
        check({tag, ".mask"},  pending_mask,              emask);
        check({tag, ".hit_a"}, {31'd0, fwd_hit_a},        {31'd0, ehit_a});
        check({tag, ".hit_b"}, {31'd0, fwd_hit_b},        {31'd0, ehit_b});
        if (ehit_a) check({tag, ".fwd_a"}, fwd_data_a, efd);
        if (ehit_b) check({tag, ".fwd_b"}, fwd_data_b, efd);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0; alu_exc = 1'b0; alu_exc_code = 32'd0;
        md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0; md_exc = 1'b0; md_exc_code = 32'd0;
    endtask

    initial begin
        // ALU only, ALU exception, collision, direct md, r0
        vecs[0]  = v(1, 5, 32'h1234, 0, 0,   0, 0, 0, 0, 0,        1, 5, 32'h1234, 1, 32'h0);
        vecs[1]  = v(1, 7, 32'h77, 1, 1,     0, 0, 0, 0, 0,        1, 30, 32'h1, 1, 32'h0);
        vecs[2]  = v(0, 0, 0, 0, 0,          0, 0, 0, 0, 0,        0, 0, 32'h0, 1, 32'h0);
        vecs[3]  = v(1, 3, 32'h33, 0, 0,     1, 9, 32'h99, 0, 0,   1, 3, 32'h33, 1, 32'h200);
        vecs[4]  = v(0, 0, 0, 0, 0,          0, 0, 0, 0, 0,        1, 9, 32'h99, 1, 32'h0);
        vecs[5]  = v(0, 0, 0, 0, 0,          1, 10, 32'h10, 0, 0,  1, 10, 32'h10, 1, 32'h0);
        vecs[6]  = v(0, 0, 0, 0, 0,          1, 11, 32'h11, 1, 5,  1, 30, 32'h5, 1, 32'h0);
        vecs[7]  = v(1, 0, 32'hFF, 0, 0,     0, 0, 0, 0, 0,        0, 0, 32'h0, 1, 32'h0);
        vecs[8]  = v(0, 0, 0, 0, 0,          1, 0, 32'hEE, 0, 0,   0, 0, 32'h0, 1, 32'h0);
        // Fill the queue, hold a third md while full, drain
        vecs[9]  = v(1, 1, 32'h01, 0, 0,     1, 12, 32'hC, 0, 0,   1, 1, 32'h01, 1, 32'h1000);
        vecs[10] = v(1, 2, 32'h02, 0, 0,     1, 13, 32'hD, 0, 0,   1, 2, 32'h02, 0, 32'h3000);
        vecs[11] = v(1, 6, 32'h06, 0, 0,     1, 14, 32'hE, 0, 0,   1, 6, 32'h06, 0, 32'h3000);
        vecs[12] = v(0, 0, 0, 0, 0,          1, 14, 32'hE, 0, 0,   1, 12, 32'hC, 1, 32'h2000);
        vecs[13] = v(0, 0, 0, 0, 0,          1, 14, 32'hE, 0, 0,   1, 13, 32'hD, 1, 32'h4000);
        vecs[14] = v(0, 0, 0, 0, 0,          0, 0, 0, 0, 0,        1, 14, 32'hE, 1, 32'h0);
        // WAW squash of a parked entry
        vecs[15] = v(1, 8, 32'h08, 0, 0,     1, 4, 32'hAA, 0, 0,   1, 8, 32'h08, 1, 32'h10);
        vecs[16] = v(1, 4, 32'hBB, 0, 0,     0, 0, 0, 0, 0,        1, 4, 32'hBB, 1, 32'h0);
        vecs[17] = v(0, 0, 0, 0, 0,          0, 0, 0, 0, 0,        0, 0, 32'h0, 1, 32'h0);
        vecs[18] = v(0, 0, 0, 0, 0,          0, 0, 0, 0, 0,        0, 0, 32'h0, 1, 32'h0);
        // Same-cycle same-register collision: md dropped
        vecs[19] = v(1, 15, 32'h1, 0, 0,     1, 15, 32'h2, 0, 0,   1, 15, 32'h1, 1, 32'h0);
        vecs[20] = v(0, 0, 0, 0, 0,          0, 0, 0, 0, 0,        0, 0, 32'h0, 1, 32'h0);
        // Park two entries ahead of the reset sequence
        vecs[21] = v(1, 16, 32'h16, 0, 0,    1, 17, 32'h17, 0, 0,  1, 16, 32'h16, 1, 32'h20000);
        vecs[22] = v(1, 18, 32'h18, 0, 0,    1, 19, 32'h19, 0, 0,  1, 18, 32'h18, 0, 32'hA0000);

        fwd_rd_a = 5'd5;
        fwd_rd_b = 5'd30;
        idle_inputs();
        ctrl_reset = 1'b1;
        repeat (2) @(negedge clock);
        check_port("reset", 1'b0, 5'd0, 32'd0, 1'b1, 32'd0);
        ctrl_reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
            alu_exc = vecs[i].aexc; alu_exc_code = vecs[i].acode;
            md_valid = vecs[i].mv; md_rd = vecs[i].mrd; md_data = vecs[i].mdata;
            md_exc = vecs[i].mexc; md_exc_code = vecs[i].mcode;
            @(negedge clock);
            check_port($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].ereg, vecs[i].edata,
                       vecs[i].erdy, vecs[i].emask);
        end

        // Reset with two parked entries and an ALU result offered in the reset cycle
        ctrl_reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        md_valid = 1'b1; md_rd = 5'd21; md_data = 32'h21;
        @(negedge clock);
        check_port("rst_cyc", 1'b0, 5'd0, 32'd0, 1'b1, 32'd0);
        ctrl_reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_port($sformatf("post_rst%0d", k), 1'b0, 5'd0, 32'd0, 1'b1, 32'd0);
        end

        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hCAFE;
        @(negedge clock);
        check_port("after_rst_alu", 1'b1, 5'd5, 32'hCAFE, 1'b1, 32'd0);
        idle_inputs();
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
